// File: rtl/pe_pkg.sv
// Shared widths, default moduli, mode encodings and modular helpers for the add/sub PE.
package pe_pkg;

    localparam int unsigned KW = 12;
    localparam int unsigned DW = 24;

    localparam int unsigned KQ_DEFAULT = 3329;
    localparam int unsigned DQ_DEFAULT = 8380417;

    localparam logic KD_KYBER = 1'b0;
    localparam logic KD_DIL   = 1'b1;

    // Operands must already be reduced (< q).
    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input logic [DW-1:0] q);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end
        return s[DW-1:0];
    endfunction

    // Wrap-around at 2^DW is harmless: the true result always lies in [0, q).
    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input logic [DW-1:0] q);
        logic [DW-1:0] d;
        d = x - y;
        if (x < y) begin
            d = d + q;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] x, input logic [DW-1:0] q);
        logic [DW:0] addend;
        addend = x[0] ? {1'b0, q} : {(DW + 1){1'b0}};
        return DW'(({1'b0, x} + addend) >> 1);
    endfunction

endpackage

// File: rtl/pe_lane.sv
// One 24-bit lane: stage-1 modular add/sub and stage-2 halve/bypass, purely combinational.
module pe_lane
    import pe_pkg::*;
#(
    parameter int unsigned KQ = KQ_DEFAULT,
    parameter int unsigned DQ = DQ_DEFAULT
) (
    input  logic          mode1,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] add_res,
    output logic [DW-1:0] sub_res,
    input  logic          mode2,
    input  logic          inv2,
    input  logic [DW-1:0] add_reg,
    input  logic [DW-1:0] sub_reg,
    output logic [DW-1:0] sum,
    output logic [DW-1:0] diff
);

    localparam logic [DW-1:0] KQ_W = DW'(KQ);
    localparam logic [DW-1:0] DQ_W = DW'(DQ);

    function automatic logic [DW-1:0] hi(input logic [DW-1:0] w);
        return {{(DW - KW){1'b0}}, w[DW-1:KW]};
    endfunction

    function automatic logic [DW-1:0] lo(input logic [DW-1:0] w);
        return {{(DW - KW){1'b0}}, w[KW-1:0]};
    endfunction

    // Both halves are < 2^KW, so shift/or rebuilds the packed word without carries.
    function automatic logic [DW-1:0] pack_kyber(input logic [DW-1:0] h, input logic [DW-1:0] l);
        return (h << KW) | l;
    endfunction

    function automatic logic [DW-1:0] word_add(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                               input logic mode);
        if (mode == KD_DIL) begin
            return mod_add(x, y, DQ_W);
        end
        return pack_kyber(mod_add(hi(x), hi(y), KQ_W), mod_add(lo(x), lo(y), KQ_W));
    endfunction

    function automatic logic [DW-1:0] word_sub(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                               input logic mode);
        if (mode == KD_DIL) begin
            return mod_sub(x, y, DQ_W);
        end
        return pack_kyber(mod_sub(hi(x), hi(y), KQ_W), mod_sub(lo(x), lo(y), KQ_W));
    endfunction

    function automatic logic [DW-1:0] word_half(input logic [DW-1:0] x, input logic mode);
        if (mode == KD_DIL) begin
            return mod_half(x, DQ_W);
        end
        return pack_kyber(mod_half(hi(x), KQ_W), mod_half(lo(x), KQ_W));
    endfunction

    assign add_res = word_add(a, b, mode1);
    assign sub_res = word_sub(a, b, mode1);
    assign sum     = inv2 ? word_half(add_reg, mode2) : add_reg;
    assign diff    = inv2 ? word_half(sub_reg, mode2) : sub_reg;

endmodule

// File: rtl/pe_addsub_pipe.sv
// Two-stage modular add/sub butterfly over LANES words with valid/ready flow control.
module pe_addsub_pipe
    import pe_pkg::*;
#(
    parameter int unsigned LANES = 1,
    parameter int unsigned KQ    = KQ_DEFAULT,
    parameter int unsigned DQ    = DQ_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  kd_mode,
    input  logic                  inv,
    input  logic [DW*LANES-1:0]   a,
    input  logic [DW*LANES-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW*LANES-1:0]   sum,
    output logic [DW*LANES-1:0]   diff
);

    localparam int unsigned W = DW * LANES;

    logic         v1_q, v2_q;
    logic         mode1_q, inv1_q;
    logic [W-1:0] add_c, sub_c, add1_q, sub1_q;
    logic [W-1:0] sum_c, diff_c, sum_q, diff_q;
    logic         adv1, adv2;

    assign in_ready  = ~flush & (~v1_q | ~v2_q | out_ready);
    assign adv1      = in_valid & in_ready;
    assign adv2      = v1_q & (~v2_q | out_ready);
    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign diff      = diff_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane #(
            .KQ (KQ),
            .DQ (DQ)
        ) u_lane (
            .mode1   (kd_mode),
            .a       (a[DW*i +: DW]),
            .b       (b[DW*i +: DW]),
            .add_res (add_c[DW*i +: DW]),
            .sub_res (sub_c[DW*i +: DW]),
            .mode2   (mode1_q),
            .inv2    (inv1_q),
            .add_reg (add1_q[DW*i +: DW]),
            .sub_reg (sub1_q[DW*i +: DW]),
            .sum     (sum_c[DW*i +: DW]),
            .diff    (diff_c[DW*i +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (adv1) begin
                v1_q <= 1'b1;
            end else if (adv2) begin
                v1_q <= 1'b0;
            end
            if (adv2) begin
                v2_q <= 1'b1;
            end else if (out_ready) begin
                v2_q <= 1'b0;
            end
        end
    end

    // Mode and inv ride along with the beat so stage 2 halves with the right modulus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode1_q <= 1'b0;
            inv1_q  <= 1'b0;
            add1_q  <= '0;
            sub1_q  <= '0;
        end else if (adv1) begin
            mode1_q <= kd_mode;
            inv1_q  <= inv;
            add1_q  <= add_c;
            sub1_q  <= sub_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q  <= '0;
            diff_q <= '0;
        end else if (adv2) begin
            sum_q  <= sum_c;
            diff_q <= diff_c;
        end
    end

endmodule

// File: tb/tb_pe_addsub_pipe.sv
// Directed and model-checked bench for pe_addsub_pipe with four lanes.
module tb_pe_addsub_pipe;

    localparam int     LANES = 4;
    localparam int     W     = 24 * LANES;
    localparam longint KQ    = 3329;
    localparam longint DQ    = 8380417;
    localparam int     NBEATS = 200;

    localparam logic [23:0] KA      = {12'd100, 12'd3000};
    localparam logic [23:0] KB      = {12'd3000, 12'd100};
    localparam logic [23:0] KS_NTT  = {12'd3100, 12'd3100};
    localparam logic [23:0] KD_NTT  = {12'd429, 12'd2900};
    localparam logic [23:0] KS_INTT = {12'd1550, 12'd1550};
    localparam logic [23:0] KD_INTT = {12'd1879, 12'd1450};

    logic         clk = 1'b0;
    logic         rst;
    logic         flush, in_valid, in_ready, kd_mode, inv, out_valid, out_ready;
    logic [W-1:0] a, b, sum, diff;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_addsub_pipe #(
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kd_mode   (kd_mode),
        .inv       (inv),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .diff      (diff)
    );

    function automatic longint ref_coef(input longint x, input longint y, input longint q,
                                        input bit is_sub, input bit half);
        longint r;
        r = is_sub ? (x - y + q) % q : (x + y) % q;
        if (half) r = (r * ((q + 1) / 2)) % q;
        return r;
    endfunction

    function automatic logic [23:0] ref_word(input logic [23:0] x, input logic [23:0] y,
                                             input bit mode, input bit is_sub, input bit half);
        longint h, l;
        if (mode) return 24'(ref_coef(longint'(x), longint'(y), DQ, is_sub, half));
        h = ref_coef(longint'(x[23:12]), longint'(y[23:12]), KQ, is_sub, half);
        l = ref_coef(longint'(x[11:0]), longint'(y[11:0]), KQ, is_sub, half);
        return {12'(h), 12'(l)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        kd_mode   = 1'b0;
        inv       = 1'b0;
        a         = '0;
        b         = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #3;
        n_checks += 4;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        if (sum !== '0) begin
            n_fail++; $display("FAIL reset_sum: got %h expected 0", sum);
        end
        if (diff !== '0) begin
            n_fail++; $display("FAIL reset_diff: got %h expected 0", diff);
        end
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_kyber_ntt();
        a = {LANES{KA}}; b = {LANES{KB}}; kd_mode = 1'b0; inv = 1'b0; in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL kntt_in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL kntt_latency_early: got %b expected 0", out_valid);
        end
        tick();
        n_checks += 3;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL kntt_latency: got %b expected 1", out_valid);
        end
        if (sum !== {LANES{KS_NTT}}) begin
            n_fail++; $display("FAIL kntt_sum: got %h expected %h", sum, {LANES{KS_NTT}});
        end
        if (diff !== {LANES{KD_NTT}}) begin
            n_fail++; $display("FAIL kntt_diff: got %h expected %h", diff, {LANES{KD_NTT}});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL kntt_single_beat: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_kyber_intt();
        a = {LANES{KA}}; b = {LANES{KB}}; kd_mode = 1'b0; inv = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks += 3;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL kintt_valid: got %b expected 1", out_valid);
        end
        if (sum !== {LANES{KS_INTT}}) begin
            n_fail++; $display("FAIL kintt_sum: got %h expected %h", sum, {LANES{KS_INTT}});
        end
        if (diff !== {LANES{KD_INTT}}) begin
            n_fail++; $display("FAIL kintt_diff: got %h expected %h", diff, {LANES{KD_INTT}});
        end
        tick();
    endtask

    task automatic test_back_to_back_dilithium();
        a = {LANES{24'd8380416}}; b = {LANES{24'd1}}; kd_mode = 1'b1; inv = 1'b0;
        in_valid = 1'b1;
        tick();
        a = {LANES{24'd3}}; b = {LANES{24'd0}}; inv = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL dntt_valid: got %b expected 1", out_valid);
        end
        if (sum !== {LANES{24'd0}}) begin
            n_fail++; $display("FAIL dntt_sum: got %h expected 0", sum);
        end
        if (diff !== {LANES{24'd8380415}}) begin
            n_fail++; $display("FAIL dntt_diff: got %h expected %h", diff, {LANES{24'd8380415}});
        end
        tick();
        n_checks += 3;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL dintt_valid: got %b expected 1", out_valid);
        end
        if (sum !== {LANES{24'd4190210}}) begin
            n_fail++; $display("FAIL dintt_sum: got %h expected %h", sum, {LANES{24'd4190210}});
        end
        if (diff !== {LANES{24'd4190210}}) begin
            n_fail++; $display("FAIL dintt_diff: got %h expected %h", diff, {LANES{24'd4190210}});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL dil_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_mixed_random();
        logic [W-1:0] ra [NBEATS];
        logic [W-1:0] rb [NBEATS];
        logic [W-1:0] es, ed;
        int  sent, rcv, cyc;
        bit  acc, m, h;
        for (int k = 0; k < NBEATS; k++) begin
            for (int l = 0; l < LANES; l++) begin
                if (k % 2 == 1) begin
                    ra[k][24*l +: 24] = 24'($urandom_range(int'(DQ) - 1, 0));
                    rb[k][24*l +: 24] = 24'($urandom_range(int'(DQ) - 1, 0));
                end else begin
                    ra[k][24*l +: 24] = {12'($urandom_range(int'(KQ) - 1, 0)),
                                         12'($urandom_range(int'(KQ) - 1, 0))};
                    rb[k][24*l +: 24] = {12'($urandom_range(int'(KQ) - 1, 0)),
                                         12'($urandom_range(int'(KQ) - 1, 0))};
                end
            end
        end
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < NBEATS && cyc < 4000) begin
            in_valid  = (sent < NBEATS) && ($urandom_range(3, 0) != 0);
            if (sent < NBEATS) begin
                a = ra[sent]; b = rb[sent];
                kd_mode = (sent % 2 == 1); inv = ((sent / 2) % 2 == 1);
            end
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                m = (rcv % 2 == 1); h = ((rcv / 2) % 2 == 1);
                for (int l = 0; l < LANES; l++) begin
                    es[24*l +: 24] = ref_word(ra[rcv][24*l +: 24], rb[rcv][24*l +: 24], m, 0, h);
                    ed[24*l +: 24] = ref_word(ra[rcv][24*l +: 24], rb[rcv][24*l +: 24], m, 1, h);
                end
                n_checks += 2;
                if (sum !== es) begin
                    n_fail++; $display("FAIL mixed_sum beat %0d: got %h expected %h", rcv, sum, es);
                end
                if (diff !== ed) begin
                    n_fail++; $display("FAIL mixed_diff beat %0d: got %h expected %h", rcv, diff, ed);
                end
                rcv++;
            end
            tick();
            if (acc) sent++;
            cyc++;
        end
        n_checks++;
        if (rcv != NBEATS) begin
            n_fail++; $display("FAIL mixed_timeout: got %0d beats expected %0d", rcv, NBEATS);
        end
        idle();
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mixed_extra_beat: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        bit exp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [23:0] es, ed;
        int sent, rcv;
        bit acc;
        sent = 0; rcv = 0;
        kd_mode = 1'b0; inv = 1'b0;
        b = {LANES{12'd1, 12'd2}};
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (sent < 6);
            a = {LANES{12'(sent + 1), 12'(sent + 10)}};
            #1;
            if (cyc < 6) begin
                n_checks++;
                if (in_ready !== exp_rdy[cyc]) begin
                    n_fail++;
                    $display("FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, in_ready,
                             exp_rdy[cyc]);
                end
            end
            acc = in_valid && in_ready;
            if (out_valid) begin
                es = {12'(rcv + 2), 12'(rcv + 12)};
                ed = {12'(rcv), 12'(rcv + 8)};
                n_checks += 2;
                if (rcv >= 6) begin
                    n_fail++; $display("FAIL bp_duplicate: got beat %0d expected at most 6", rcv + 1);
                end else if (sum !== {LANES{es}}) begin
                    n_fail++; $display("FAIL bp_sum beat %0d: got %h expected %h", rcv, sum, {LANES{es}});
                end
                if (rcv < 6 && diff !== {LANES{ed}}) begin
                    n_fail++; $display("FAIL bp_diff beat %0d: got %h expected %h", rcv, diff, {LANES{ed}});
                end
                if (out_ready) rcv++;
            end
            tick();
            if (acc) sent++;
        end
        n_checks++;
        if (rcv != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d beats expected 6", rcv);
        end
        idle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; kd_mode = 1'b0; inv = 1'b0; in_valid = 1'b1;
        a = {LANES{KA}}; b = {LANES{KB}};
        tick();
        tick();
        flush = 1'b1;
        #1;
        n_checks += 2;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready);
        end
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_in_flight: got %b expected 1", out_valid);
        end
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_output cyc %0d: got %b expected 0", i, out_valid);
            end
            tick();
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready_after: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_async_reset();
        a = {LANES{24'd5}}; b = {LANES{24'd2}}; kd_mode = 1'b1; inv = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        tick();
        n_checks += 2;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre_valid: got %b expected 1", out_valid);
        end
        if (sum !== {LANES{24'd7}}) begin
            n_fail++; $display("FAIL areset_pre_sum: got %h expected %h", sum, {LANES{24'd7}});
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_valid: got %b expected 0", out_valid);
        end
        if (sum !== '0) begin
            n_fail++; $display("FAIL areset_sum: got %h expected 0", sum);
        end
        if (diff !== '0) begin
            n_fail++; $display("FAIL areset_diff: got %h expected 0", diff);
        end
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL areset_stale cyc %0d: got %b expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected bench end");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        test_reset();
        test_kyber_ntt();
        test_kyber_intt();
        test_back_to_back_dilithium();
        test_mixed_random();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
